// File: rtl/new_pc.sv
// new_pc: next-program-counter unit.
// Selects the next fetch address from the current PC and one of several
// sources (sequential, conditional/unconditional relative branch, absolute
// jump, interrupt vector, call-stack return) and registers it into PC_o.
// Interface contract: there is no valid/ready handshake; the register
// captures a new value on every rising clk_i edge while rst_ni is high, and
// a stall is requested by the decoder with the hold code (0001).
module new_pc (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [3:0]  PCoper_i,
  input  logic        zero_i,
  input  logic        carry_i,
  input  logic [11:0] int_i,
  input  logic [11:0] stk_i,
  input  logic [7:0]  offset_i,
  input  logic [11:0] jump_i,
  input  logic [11:0] PC_i,
  output logic [11:0] PC_o
);

  // Operation codes driven by the decoder.
  localparam logic [3:0] OP_SEQ  = 4'b0000;
  localparam logic [3:0] OP_HOLD = 4'b0001;
  localparam logic [3:0] OP_BZ   = 4'b0100;
  localparam logic [3:0] OP_BNZ  = 4'b0101;
  localparam logic [3:0] OP_BC   = 4'b0110;
  localparam logic [3:0] OP_BNC  = 4'b0111;
  localparam logic [3:0] OP_JMP  = 4'b1000;
  localparam logic [3:0] OP_INT  = 4'b1010;
  localparam logic [3:0] OP_BRA  = 4'b1011;
  localparam logic [3:0] OP_RET  = 4'b1100;

  // Source chosen for the next PC; the code alone decides, no priority.
  typedef enum logic [2:0] {
    SRC_SEQ  = 3'd0,
    SRC_HOLD = 3'd1,
    SRC_REL  = 3'd2,
    SRC_JMP  = 3'd3,
    SRC_INT  = 3'd4,
    SRC_RET  = 3'd5
  } src_e;

  src_e        src;
  logic [11:0] pc_seq;
  logic [11:0] pc_rel;
  logic [11:0] disp;
  logic [11:0] nxt;

  // Sign-extended displacement; the branch base is PC_i itself, and both
  // additions wrap silently modulo 4096.
  assign disp   = {{4{offset_i[7]}}, offset_i};
  assign pc_seq = PC_i + 12'd1;
  assign pc_rel = PC_i + disp;

  // Decode the operation code into a source; flags only affect 0100-0111.
  always_comb begin
    src = SRC_SEQ;
    case (PCoper_i)
      OP_SEQ:  src = SRC_SEQ;
      OP_HOLD: src = SRC_HOLD;
      OP_BZ:   src = zero_i    ? SRC_REL : SRC_SEQ;
      OP_BNZ:  src = !zero_i   ? SRC_REL : SRC_SEQ;
      OP_BC:   src = carry_i   ? SRC_REL : SRC_SEQ;
      OP_BNC:  src = !carry_i  ? SRC_REL : SRC_SEQ;
      OP_JMP:  src = SRC_JMP;
      OP_INT:  src = SRC_INT;
      OP_BRA:  src = SRC_REL;
      OP_RET:  src = SRC_RET;
      default: src = SRC_SEQ;
    endcase
  end

  // Route the selected source onto the next-PC bus.
  always_comb begin
    nxt = pc_seq;
    case (src)
      SRC_SEQ:  nxt = pc_seq;
      SRC_HOLD: nxt = PC_i;
      SRC_REL:  nxt = pc_rel;
      SRC_JMP:  nxt = jump_i;
      SRC_INT:  nxt = int_i;
      SRC_RET:  nxt = stk_i;
      default:  nxt = pc_seq;
    endcase
  end

  // PC register: async clear to 0, otherwise load nxt every edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) PC_o <= 12'h000;
    else         PC_o <= nxt;
  end

endmodule

// File: tb/tb_new_pc.sv
// tb_new_pc: directed test-plan steps with literal expectations, then
// randomized operation against a behavioural next-PC model. A monitor
// queues the expected PC_o at each rising edge; a compare process checks
// it on the following falling edge.
module tb_new_pc;

  logic        clk;
  logic        rst_n;
  logic [3:0]  pcoper;
  logic        zero;
  logic        carry;
  logic [11:0] int_v;
  logic [11:0] stk_v;
  logic [7:0]  offset;
  logic [11:0] jump_v;
  logic [11:0] pc_in;
  logic [11:0] pc_out;

  int errors = 0;
  int checks = 0;
  logic [11:0] exp_q[$];

  new_pc dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .PCoper_i (pcoper),
    .zero_i   (zero),
    .carry_i  (carry),
    .int_i    (int_v),
    .stk_i    (stk_v),
    .offset_i (offset),
    .jump_i   (jump_v),
    .PC_i     (pc_in),
    .PC_o     (pc_out)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural next-PC rule computed with plain integer arithmetic.
  function automatic logic [11:0] model(input logic [3:0] code, input logic z,
                                        input logic c, input logic [11:0] iv,
                                        input logic [11:0] sv, input logic [7:0] off,
                                        input logic [11:0] jv, input logic [11:0] pc);
    int seq_t;
    int rel_t;
    bit take;
    seq_t = (int'(pc) + 1) % 4096;
    rel_t = (int'(pc) + int'($signed(off)) + 4096) % 4096;
    case (code)
      4'd0:    return 12'(seq_t);
      4'd1:    return pc;
      4'd4, 4'd5, 4'd6, 4'd7: begin
        take = (code[1] ? c : z) ^ code[0];
        return take ? 12'(rel_t) : 12'(seq_t);
      end
      4'd8:    return jv;
      4'd10:   return iv;
      4'd11:   return 12'(rel_t);
      4'd12:   return sv;
      default: return 12'(seq_t);
    endcase
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: PC_o=%03h expected=%03h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: expected value captured at each rising edge
  always @(posedge clk) begin
    if (rst_n)
      exp_q.push_back(model(pcoper, zero, carry, int_v, stk_v, offset, jump_v, pc_in));
    else
      exp_q.push_back(12'h000);
  end

  // compare process: every falling edge, reset overrides any queued update
  always @(negedge clk) begin
    logic [11:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (!rst_n) e = 12'h000;
      check("model", pc_out, e);
    end
  end

  // driver tasks
  task automatic set_common();
    pc_in = 12'h000; zero = 1'b1; carry = 1'b1; int_v = 12'h002;
    stk_v = 12'h003; offset = 8'h08; jump_v = 12'h007;
  endtask

  task automatic step(input logic [3:0] code, input logic [11:0] lit, input string name);
    pcoper = code;
    @(posedge clk);
    #1 check(name, pc_out, lit);
  endtask

  initial begin
    rst_n = 1'b0;
    set_common();
    pcoper = 4'b0000;
    #3 check("reset_state", pc_out, 12'h000);
    @(posedge clk);
    #1 check("reset_held", pc_out, 12'h000);
    #3 rst_n = 1'b1;

    step(4'b0000, 12'h001, "seq_first");
    pc_in = 12'hFFF;
    step(4'b0000, 12'h000, "seq_wrap");
    set_common();
    step(4'b0100, 12'h008, "bz_taken");
    step(4'b0110, 12'h008, "bc_taken");
    step(4'b0101, 12'h001, "bnz_not");
    step(4'b0111, 12'h001, "bnc_not");
    zero = 1'b0; carry = 1'b0;
    step(4'b0100, 12'h001, "bz_not");
    step(4'b0110, 12'h001, "bc_not");
    step(4'b0101, 12'h008, "bnz_taken");
    step(4'b0111, 12'h008, "bnc_taken");
    set_common();
    offset = 8'hF8; pc_in = 12'h010;
    step(4'b1011, 12'h008, "bra_back");
    pc_in = 12'h004;
    step(4'b1011, 12'hFFC, "bra_wrap");
    set_common();
    step(4'b1010, 12'h002, "int");
    step(4'b1100, 12'h003, "ret");
    pc_in = 12'h123;
    step(4'b0001, 12'h123, "hold");
    set_common();
    step(4'b1111, 12'h001, "unused");
    step(4'b1000, 12'h007, "jump");

    // asynchronous reset mid-cycle while PC_o=0x007
    #2 rst_n = 1'b0;
    #1 check("async_reset", pc_out, 12'h000);
    @(negedge clk);
    #1 rst_n = 1'b1;
    pcoper = 4'b0000; pc_in = 12'h000;
    @(posedge clk);
    #1 check("post_reset_seq", pc_out, 12'h001);

    // randomized operation
    for (int i = 0; i < 400; i++) begin
      pcoper = 4'($urandom_range(0, 15));
      zero   = 1'($urandom_range(0, 1));
      carry  = 1'($urandom_range(0, 1));
      int_v  = 12'($urandom);
      stk_v  = 12'($urandom);
      offset = 8'($urandom);
      jump_v = 12'($urandom);
      pc_in  = (i % 8 == 0) ? 12'($urandom_range(4064, 4095)) : 12'($urandom);
      @(posedge clk);
      #1;
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
